// File: rtl/spi_shift_engine.sv
// Byte-serial SPI shift engine: MSB-first, one byte per IDLE/SHIFT/DONE pass.
// Define SPI_SHIFT_MODE_EN to add cpol_i/cpha_i; otherwise fixed mode 0.
module spi_shift_engine #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        enable_i,
  input  logic [31:0] spi_write_data_i,
  input  logic [2:0]  spi_write_data_bytes_valid_i,
  input  logic        reset_fill_level_i,
  input  logic        spi_miso_i,
`ifdef SPI_SHIFT_MODE_EN
  input  logic        cpol_i,
  input  logic        cpha_i,
`endif
  output logic        spi_mosi_o,
  output logic        spi_clk_o,
  output logic [31:0] spi_read_data_o,
  output logic [2:0]  spi_read_data_bytes_valid_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    bv_lim;
  logic [2:0]    count_q;
  logic [DW-1:0] div_q;
  logic [3:0]    ecnt_q;
  logic [7:0]    tx_q;
  logic [7:0]    rx_q;
  logic [7:0]    ld_byte;
  logic [31:0]   rdata_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          drop_q;
  logic          cpha_q;
  logic          cpol_in;
  logic          cpha_in;
  logic          start;
  logic          tick;
  logic          sample_ev;
  logic          drive_ev;

`ifdef SPI_SHIFT_MODE_EN
  assign cpol_in = cpol_i;
  assign cpha_in = cpha_i;
`else
  assign cpol_in = 1'b0;
  assign cpha_in = 1'b0;
`endif

  always_comb begin
    bv_lim    = (spi_write_data_bytes_valid_i > 3'd4) ? 3'd4
              : spi_write_data_bytes_valid_i;
    ld_byte   = spi_write_data_i[{count_q[1:0], 3'b000} +: 8];
    tick      = (state_q == SHIFT) && (div_q == DIV_LAST);
    // Even edges are leading; CPHA picks which edge parity samples.
    sample_ev = tick && (ecnt_q[0] == cpha_q);
    drive_ev  = tick && (ecnt_q[0] != cpha_q);
    start     = 1'b0;
    state_d   = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_q < bv_lim) begin
            start   = 1'b1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (tick && ecnt_q == 4'd15) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_q <= '0;
      div_q   <= '0;
      ecnt_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      drop_q  <= 1'b0;
      cpha_q  <= 1'b0;
    end else if (!enable_i) begin
      count_q <= '0;
      div_q   <= '0;
      ecnt_q  <= '0;
      sclk_q  <= cpol_in;
      mosi_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      if (reset_fill_level_i) count_q <= '0;
      unique case (state_q)
        IDLE: begin
          sclk_q <= cpol_in;
          mosi_q <= 1'b0;
          if (start) begin
            cpha_q <= cpha_in;
            div_q  <= '0;
            ecnt_q <= '0;
            rx_q   <= '0;
            drop_q <= reset_fill_level_i;
            // CPHA=0 puts the MSB out on entry, CPHA=1 on the first edge.
            if (cpha_in) begin
              tx_q <= ld_byte;
            end else begin
              tx_q   <= {ld_byte[6:0], 1'b0};
              mosi_q <= ld_byte[7];
            end
          end
        end
        SHIFT: begin
          if (reset_fill_level_i) drop_q <= 1'b1;
          if (tick) begin
            div_q  <= '0;
            ecnt_q <= ecnt_q + 4'd1;
            sclk_q <= ~sclk_q;
          end else begin
            div_q <= div_q + DW'(1);
          end
          if (sample_ev) rx_q <= {rx_q[6:0], spi_miso_i};
          if (drive_ev) begin
            mosi_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
          end
        end
        DONE: begin
          mosi_q <= 1'b0;
          if (!drop_q && !reset_fill_level_i) begin
            rdata_q[{count_q[1:0], 3'b000} +: 8] <= rx_q;
            count_q <= (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
          end
        end
        default: mosi_q <= 1'b0;
      endcase
    end
  end

  assign spi_mosi_o                  = mosi_q;
  assign spi_clk_o                   = sclk_q;
  assign spi_read_data_o             = rdata_q;
  assign spi_read_data_bytes_valid_o = count_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench for spi_shift_engine: wire bytes and received bytes
// are queued at issue time and checked by independent monitors.
module tb_spi_shift_engine;

  localparam int DIV  = 4;
  localparam int BYTE = 16 * DIV + 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [31:0] wdata;
  logic [2:0]  bvin;
  logic        fill_clr;
  logic        miso;
  logic        mosi;
  logic        sclk;
  logic [31:0] rdata;
  logic [2:0]  cnt;
  logic        inv_q;
  logic        tb_cpol = 1'b0;
  logic        tb_cpha = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ref_cyc = 0;
  int rises  = 0;
  bit chk_timing = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  assign miso = mosi ^ inv_q;

  spi_shift_engine #(.CLK_DIV(DIV)) dut (
    .clk_i                        (clk),
    .rstn_i                       (rstn),
    .enable_i                     (enable),
    .spi_write_data_i             (wdata),
    .spi_write_data_bytes_valid_i (bvin),
    .reset_fill_level_i           (fill_clr),
    .spi_miso_i                   (miso),
`ifdef SPI_SHIFT_MODE_EN
    .cpol_i                       (tb_cpol),
    .cpha_i                       (tb_cpha),
`endif
    .spi_mosi_o                   (mosi),
    .spi_clk_o                    (sclk),
    .spi_read_data_o              (rdata),
    .spi_read_data_bytes_valid_o  (cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Wire monitor: collect MOSI on the sampling edge of the active mode.
  logic [7:0] sh = '0;
  int         bitcnt = 0;
  logic       sclk_prev = 1'b0;
  logic [2:0] cnt_prev = '0;

  always @(negedge clk) begin
    if (!rstn || !enable) begin
      bitcnt = 0;
    end else if (sclk !== sclk_prev && sclk === ~(tb_cpol ^ tb_cpha)) begin
      sh = {sh[6:0], mosi};
      bitcnt++;
      if (bitcnt == 8) begin
        bitcnt = 0;
        if (exp_tx.size() == 0) chk("tx_unexpected", {24'h0, sh}, 32'hxx);
        else chk("tx_byte", {24'h0, sh}, {24'h0, exp_tx.pop_front()});
      end
    end
    if (rstn && sclk === 1'b1 && sclk_prev === 1'b0) rises++;
    sclk_prev = sclk;
  end

  // Fill-level monitor: each increment exposes one received byte.
  always @(negedge clk) begin
    if (rstn && cnt == cnt_prev + 3'd1) begin
      int ci;
      ci = int'(cnt);
      if (exp_rx.size() == 0) begin
        chk("rx_unexpected", {24'h0, rdata[8*(ci-1) +: 8]}, 32'hxx);
      end else begin
        chk("rx_byte", {24'h0, rdata[8*(ci-1) +: 8]},
            {24'h0, exp_rx.pop_front()});
      end
      if (chk_timing) begin
        chk("byte_period", cyc - ref_cyc, BYTE);
        ref_cyc = cyc;
      end
    end
    cnt_prev = cnt;
  end

  task automatic wait_count(int tgt, int budget);
    int c = 0;
    while (int'(cnt) != tgt && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (int'(cnt) != tgt) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_count: got %0d expected %0d", cnt, tgt);
    end
  endtask

  task automatic push_bytes(logic [31:0] d, int first, int n, logic inv);
    for (int k = first; k < first + n; k++) begin
      exp_tx.push_back(d[8*k +: 8]);
      exp_rx.push_back(d[8*k +: 8] ^ {8{inv}});
    end
  endtask

  task automatic queues_empty(string nm);
    chk({nm, "_tx_left"}, exp_tx.size(), 0);
    chk({nm, "_rx_left"}, exp_rx.size(), 0);
  endtask

  task automatic session(logic [31:0] d, logic [2:0] bv, logic inv);
    int n;
    int r0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    n = (bv > 3'd4) ? 4 : int'(bv);
    wdata = d;
    bvin  = bv;
    inv_q = inv;
    push_bytes(d, 0, n, inv);
    r0 = rises;
    enable = 1'b1;
    ref_cyc = cyc;
    chk_timing = 1;
    wait_count(n, n * BYTE + 20);
    @(negedge clk);
    chk("count_final", cnt, n);
    for (int k = 0; k < n; k++)
      chk("rdata_byte", rdata[8*k +: 8], d[8*k +: 8] ^ {8{inv}});
    repeat (60) @(negedge clk);
    chk("sclk_edges", rises - r0, 8 * n);
    chk_timing = 0;
    queues_empty("session");
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  rd;
    int          r0;
    int          c;
    rstn = 1'b0;
    enable = 1'b0;
    wdata = '0;
    bvin = '0;
    fill_clr = 1'b0;
    inv_q = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_count", cnt, 0);
    rstn = 1'b1;
    @(negedge clk);

    session(32'h0000_00A5, 3'd1, 1'b0);
    session(32'h1234_5678, 3'd4, 1'b0);
    session(32'hDEAD_BEEF, 3'd0, 1'b0);
    session(32'hCAFE_F00D, 3'd7, 1'b1);
    for (int i = 0; i < 6; i++)
      session($urandom, 3'($urandom_range(0, 7)), 1'($urandom));

    // Fill-level clear in the middle of the second byte.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    d = $urandom;
    wdata = d;
    bvin = 3'd4;
    inv_q = 1'b0;
    push_bytes(d, 0, 2, 1'b0);
    push_bytes(d, 0, 4, 1'b0);
    exp_rx.delete(1);
    enable = 1'b1;
    wait_count(1, BYTE + 10);
    repeat (30) @(negedge clk);
    fill_clr = 1'b1;
    @(negedge clk);
    fill_clr = 1'b0;
    chk("fill_clr_count", cnt, 0);
    rd = rdata[15:8];
    repeat (40) @(negedge clk);
    chk("fill_after_done", cnt, 0);
    chk("fill_keep_b1", rdata[15:8], rd);
    wait_count(4, 5 * BYTE);
    @(negedge clk);
    chk("fill_final", rdata, d);
    queues_empty("fill");

    // Abort on enable drop after three SCLK rises of byte 1.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    d = $urandom | 32'h0000_FF00;
    wdata = d;
    push_bytes(d, 0, 1, 1'b0);
    enable = 1'b1;
    wait_count(1, BYTE + 10);
    r0 = rises;
    c = 0;
    while (rises - r0 < 3 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("abort_rises", rises - r0, 3);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_sclk", sclk, 0);
    chk("abort_mosi", mosi, 0);
    chk("abort_count", cnt, 0);
    chk("abort_keep", rdata[7:0], d[7:0]);
    queues_empty("abort");

    // Synchronous reset during the second byte, then restart from byte 0.
    d = $urandom;
    wdata = d;
    bvin = 3'd2;
    push_bytes(d, 0, 1, 1'b0);
    enable = 1'b1;
    wait_count(1, BYTE + 10);
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mrst_sclk", sclk, 0);
    chk("mrst_mosi", mosi, 0);
    chk("mrst_rdata", rdata, 0);
    chk("mrst_count", cnt, 0);
    queues_empty("mrst");
    push_bytes(d, 0, 2, 1'b0);
    rstn = 1'b1;
    wait_count(2, 2 * BYTE + 10);
    @(negedge clk);
    chk("mrst_restart", rdata[15:0], d[15:0]);
    queues_empty("restart");

`ifdef SPI_SHIFT_MODE_EN
    enable = 1'b0;
    tb_cpol = 1'b1;
    tb_cpha = 1'b1;
    repeat (3) @(negedge clk);
    chk("mode3_idle_sclk", sclk, 1);
    session(32'h0000_003C, 3'd1, 1'b0);
    chk("mode3_after_sclk", sclk, 1);
    for (int i = 0; i < 4; i++) begin
      enable = 1'b0;
      tb_cpol = 1'($urandom);
      tb_cpha = 1'($urandom);
      repeat (3) @(negedge clk);
      session($urandom, 3'($urandom_range(1, 4)), 1'($urandom));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
